// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation and fetch stage in front of a
// combinational-read instruction memory. Each fetched word is captured
// together with its PC into a small circular buffer and handed to decode
// over a valid/ready handshake. Redirects flush the buffer and restart
// fetch at the new PC. A misaligned or out-of-range PC produces one
// faulted NOP entry, and fetch then halts until the next redirect.
//
// Optional build macro: IF_PERF_CNT_EN adds the perf_fetch_cnt and
// perf_stall_cnt outputs.
//
// state    | meaning
// ST_RUN   | fetching one word per cycle while the buffer has room
// ST_FAULT | faulted entry already queued; no fetch until a redirect
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          IMEM_BYTES = 4096,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_fault
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int          PTR_W  = $clog2(FIFO_DEPTH);
   localparam int          CNT_W  = PTR_W + 1;
   localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

   typedef enum logic {ST_RUN, ST_FAULT} state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [31:0]        fifo_pc    [FIFO_DEPTH];
   logic [31:0]        fifo_instr [FIFO_DEPTH];
   logic               fifo_fault [FIFO_DEPTH];

   logic               head_valid;
   logic               full;
   logic               handshake;
   logic               pop;
   logic               fetch;
   logic               pc_bad;

   // Handshake, fetch decision and next-state for PC, pointers and state.
   // Redirect wins over everything, including a pop in the same cycle.
   always_comb begin
      head_valid = (count_q != '0);
      full       = (count_q == CNT_W'(FIFO_DEPTH));
      handshake  = head_valid && if_ready;
      pc_bad     = (pc_q[1:0] != 2'b00) || (pc_q > PC_MAX);
      pop        = handshake && !redirect_valid;
      fetch      = (state_q == ST_RUN) && !redirect_valid && (!full || handshake);

      state_d  = state_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (redirect_valid) begin
         state_d  = ST_RUN;
         pc_d     = redirect_pc;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fetch) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pc_bad) begin
               state_d = ST_FAULT;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (fetch && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!fetch && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Control state: FSM, PC and buffer bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Buffer storage; contents are only observed through the occupancy
   // count, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (fetch) begin
         fifo_pc[wr_ptr_q]    <= pc_q;
         fifo_instr[wr_ptr_q] <= pc_bad ? NOP_INSTR : imem_rdata;
         fifo_fault[wr_ptr_q] <= pc_bad;
      end
   end

   // Head of the buffer to decode; fields read as zero while empty.
   always_comb begin
      imem_addr   = pc_q;
      if_valid    = head_valid;
      if_instr    = head_valid ? fifo_instr[rd_ptr_q] : 32'd0;
      if_pc       = head_valid ? fifo_pc[rd_ptr_q] : 32'd0;
      if_fault    = head_valid ? fifo_fault[rd_ptr_q] : 1'b0;
      if_pc_plus4 = if_pc + 32'd4;
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Good-fetch and full-buffer stall counters; redirects leave them alone.
   always_comb begin
      perf_fetch_d = perf_fetch_q;
      perf_stall_d = perf_stall_q;
      if (fetch && !pc_bad) begin
         perf_fetch_d = perf_fetch_q + 32'd1;
      end
      if ((state_q == ST_RUN) && full && !handshake) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, async reset sequence,
// and a randomized run against a queue-based reference model.
module tb_instruction_fetch;

   localparam int          DEPTH   = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] MEM_TOP = 32'd4096;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_fault;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   instruction_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_fault       (if_fault)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + a;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compares the whole head view against an expected entry.
   task automatic chk_head(input string tag, input logic ev, input logic [31:0] epc,
                           input logic ef, input logic [31:0] eaddr);
      chk({tag, "_valid"}, 32'(if_valid), 32'(ev));
      chk({tag, "_addr"}, imem_addr, eaddr);
      if (ev) begin
         chk({tag, "_pc"}, if_pc, epc);
         chk({tag, "_fault"}, 32'(if_fault), 32'(ef));
         chk({tag, "_instr"}, if_instr, ef ? NOP : mem_word(epc));
         chk({tag, "_pc4"}, if_pc_plus4, epc + 32'd4);
      end
   endtask

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic        ef;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic rd, input logic [31:0] rp,
                      input logic ev, input logic [31:0] epc, input logic ef,
                      input logic [31:0] ea);
      vec_t v;
      v.ready = r; v.redir = rd; v.rpc = rp;
      v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = ea;
      vq.push_back(v);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic        m_run;
   int unsigned m_fetch;
   int unsigned m_stall;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      if_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      #2;
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_fault", 32'(if_fault), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;

      // Backpressure from reset, release, redirect with full buffer,
      // misaligned redirect, resume, and end-of-memory range fault.
      add(0, 0, 0,        1, 32'h000, 0, 32'h004);
      add(0, 0, 0,        1, 32'h000, 0, 32'h008);
      add(0, 0, 0,        1, 32'h000, 0, 32'h008);
      add(0, 0, 0,        1, 32'h000, 0, 32'h008);
      add(0, 0, 0,        1, 32'h000, 0, 32'h008);
      add(0, 0, 0,        1, 32'h000, 0, 32'h008);
      add(1, 0, 0,        1, 32'h004, 0, 32'h00C);
      add(1, 0, 0,        1, 32'h008, 0, 32'h010);
      add(1, 0, 0,        1, 32'h00C, 0, 32'h014);
      add(1, 1, 32'h100,  0, 0,       0, 32'h100);
      add(1, 0, 0,        1, 32'h100, 0, 32'h104);
      add(1, 0, 0,        1, 32'h104, 0, 32'h108);
      add(1, 1, 32'h102,  0, 0,       0, 32'h102);
      add(0, 0, 0,        1, 32'h102, 1, 32'h102);
      add(1, 0, 0,        0, 0,       0, 32'h102);
      add(1, 0, 0,        0, 0,       0, 32'h102);
      add(1, 1, 32'h200,  0, 0,       0, 32'h200);
      add(1, 0, 0,        1, 32'h200, 0, 32'h204);
      add(1, 1, 32'hFF8,  0, 0,       0, 32'hFF8);
      add(1, 0, 0,        1, 32'hFF8, 0, 32'hFFC);
      add(1, 0, 0,        1, 32'hFFC, 0, 32'h1000);
      add(1, 0, 0,        1, 32'h1000,1, 32'h1000);
      add(1, 0, 0,        0, 0,       0, 32'h1000);
      add(1, 0, 0,        0, 0,       0, 32'h1000);

      do_reset();
      foreach (vq[i]) begin
         if_ready = vq[i].ready;
         redirect_valid = vq[i].redir;
         redirect_pc = vq[i].rpc;
         @(posedge clk);
         @(negedge clk);
         chk_head($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].ef, vq[i].eaddr);
`ifdef IF_PERF_CNT_EN
         if (i == 5) chk("perf_stall_bp", perf_stall_cnt, 32'd4);
`endif
      end

      // Asynchronous reset between edges while an entry is valid.
      if_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk_head("pre_arst", 1'b1, 32'h40, 1'b0, 32'h44);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(if_valid), 32'd0);
      chk("arst_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      if_ready = 1'b1;
      @(negedge clk);
      chk_head("arst_restart0", 1'b1, 32'h0, 1'b0, 32'h4);
      @(negedge clk);
      chk_head("arst_restart1", 1'b1, 32'h4, 1'b0, 32'h8);

      // Randomized run against the queue model.
      do_reset();
      m_pc = 32'd0;
      m_run = 1'b1;
      m_fetch = 0;
      m_stall = 0;
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         logic        hs;
         logic        bad;
         ent_t        e;
         logic [31:0] rpc;

         chk("rnd_valid", 32'(if_valid), 32'(mq.size() > 0));
         chk("rnd_addr", imem_addr, m_pc);
         if (mq.size() > 0) begin
            chk("rnd_pc", if_pc, mq[0].pc);
            chk("rnd_fault", 32'(if_fault), 32'(mq[0].fault));
            chk("rnd_instr", if_instr, mq[0].fault ? NOP : mem_word(mq[0].pc));
            chk("rnd_pc4", if_pc_plus4, mq[0].pc + 32'd4);
         end

         case ($urandom_range(0, 7))
            0: rpc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            1: rpc = 32'hFF0 + (32'($urandom_range(0, 3)) << 2);
            2: rpc = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            3: rpc = 32'hFFFF_FFFC;
            default: rpc = 32'($urandom_range(0, 1023)) << 2;
         endcase
         if_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc = rpc;

         hs = (mq.size() > 0) && if_ready;
         if (m_run && mq.size() == DEPTH && !hs) m_stall++;
         if (redirect_valid) begin
            mq.delete();
            m_pc = rpc;
            m_run = 1'b1;
         end else begin
            if (hs) void'(mq.pop_front());
            if (m_run && mq.size() < DEPTH) begin
               bad = (m_pc % 4 != 0) || (m_pc + 32'd4 > MEM_TOP) || (m_pc > MEM_TOP);
               e.pc = m_pc;
               e.fault = bad;
               mq.push_back(e);
               if (bad) m_run = 1'b0;
               else begin
                  m_pc = m_pc + 32'd4;
                  m_fetch++;
               end
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_rnd", perf_fetch_cnt, 32'(m_fetch));
      chk("perf_stall_rnd", perf_stall_cnt, 32'(m_stall));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
